// File: rtl/risc_v_data_memory.sv
// Byte-addressable RV32 data memory: sized loads/stores with byte-lane writes, sign/zero
// extension, error flagging and a READ_LATENCY-deep response pipeline.
module risc_v_data_memory #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MEM_WORDS    = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int          IDX_W       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] MEM_WORDS_U = MEM_WORDS;

  logic        ready_q;
  logic        accept;
  logic [31:0] word_idx;
  logic [IDX_W-1:0] mem_idx;
  logic        f3_illegal;
  logic        misalign;
  logic        out_of_range;
  logic        req_err;
  logic        write_en;
  logic [3:0]  lane_en;
  logic [31:0] lane_wdata;

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] rd_word_q;

  logic        s1_valid_q;
  logic        s1_err_q;
  logic        s1_load_q;
  logic [2:0]  s1_funct3_q;
  logic [1:0]  s1_lane_q;
  logic [31:0] s1_shifted;
  logic [31:0] s1_ext;
  logic [33:0] s1_bundle;
  logic [33:0] rsp_bundle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  assign req_ready = ready_q;
  assign accept    = req_valid & ready_q;

  assign word_idx     = 32'(req_addr[ADDR_WIDTH-1:2]);
  assign mem_idx      = req_addr[IDX_W+1:2];
  assign out_of_range = (word_idx >= MEM_WORDS_U);
  // 011/110/111 are never legal; the unsigned forms only exist for loads.
  assign f3_illegal   = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11) |
                        (req_we & req_funct3[2]);
  assign misalign     = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                        ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
  assign req_err      = f3_illegal | misalign | out_of_range;
  assign write_en     = accept & req_we & ~req_err;

  always_comb begin
    lane_en    = 4'b1111;
    lane_wdata = req_wdata;
    unique case (req_funct3[1:0])
      2'b00: begin
        lane_en    = 4'b0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_en    = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        lane_en    = 4'b1111;
        lane_wdata = req_wdata;
      end
    endcase
  end

  // Array has no reset so contents survive rst_n; read is old data on a same-edge write.
  always_ff @(posedge clk) begin
    if (accept) rd_word_q <= mem_q[mem_idx];
    for (int i = 0; i < 4; i++) begin
      if (write_en && lane_en[i]) mem_q[mem_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_load_q   <= 1'b0;
      s1_funct3_q <= 3'b000;
      s1_lane_q   <= 2'b00;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_err_q    <= req_err;
        s1_load_q   <= ~req_we;
        s1_funct3_q <= req_funct3;
        s1_lane_q   <= req_addr[1:0];
      end
    end
  end

  always_comb begin
    s1_shifted = rd_word_q >> {s1_lane_q, 3'b000};
    unique case (s1_funct3_q)
      3'b000:  s1_ext = {{24{s1_shifted[7]}}, s1_shifted[7:0]};
      3'b100:  s1_ext = {24'h0, s1_shifted[7:0]};
      3'b001:  s1_ext = {{16{s1_shifted[15]}}, s1_shifted[15:0]};
      3'b101:  s1_ext = {16'h0, s1_shifted[15:0]};
      default: s1_ext = rd_word_q;
    endcase
  end

  assign s1_bundle = {s1_valid_q, s1_valid_q & s1_err_q,
                      (s1_valid_q & s1_load_q & ~s1_err_q) ? s1_ext : 32'h0};

  genvar gi;
  generate
    for (gi = 0; gi < READ_LATENCY - 1; gi++) begin : g_stage
      logic [33:0] stage_d;
      logic [33:0] stage_q;
      if (gi == 0) begin : g_first
        assign stage_d = s1_bundle;
      end else begin : g_next
        assign stage_d = g_stage[gi-1].stage_q;
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q <= '0;
        else        stage_q <= stage_d;
      end
    end

    if (READ_LATENCY == 1) begin : g_out_direct
      assign rsp_bundle = s1_bundle;
    end else begin : g_out_piped
      assign rsp_bundle = g_stage[READ_LATENCY-2].stage_q;
    end
  endgenerate

  assign rsp_valid = rsp_bundle[33];
  assign rsp_err   = rsp_bundle[32];
  assign rsp_rdata = rsp_bundle[31:0];

endmodule

// File: tb/tb_risc_v_data_memory.sv
// Drives three memories (READ_LATENCY 1,2,3) with one request stream and compares every
// cycle of each response port against a byte-array reference model.
module tb_risc_v_data_memory;

  localparam int AW    = 12;
  localparam int WORDS = 768;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  always #5 clk = ~clk;

  risc_v_data_memory #(.ADDR_WIDTH(AW), .MEM_WORDS(WORDS), .READ_LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));
  risc_v_data_memory #(.ADDR_WIDTH(AW), .MEM_WORDS(WORDS), .READ_LATENCY(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));
  risc_v_data_memory #(.ADDR_WIDTH(AW), .MEM_WORDS(WORDS), .READ_LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[2]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
  } acc_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat [3] = '{1, 2, 3};
  int          head [3] = '{0, 0, 0};
  acc_t        acc_q [$];
  logic [7:0]  ref_mem [WORDS*4];
  logic        ready_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: byte-addressed memory, little-endian, computed straight from the ISA rules.
  task automatic model(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                       input logic [31:0] wd, output logic err, output logic [31:0] data);
    int base;
    int n;
    logic [31:0] v;
    base = int'(a);
    err  = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && (f3 == 4 || f3 == 5)) ||
           ((f3 == 1 || f3 == 5) && a[0]) || (f3 == 2 && a[1:0] != 2'b00) ||
           (base / 4 >= WORDS);
    n    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    data = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base + i];
        if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
        data = v;
      end
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ready_l%0d", lat[k]), 32'(req_ready[k]), 32'(ready_m));
      if (head[k] < acc_q.size() && acc_q[head[k]].cyc + lat[k] - 1 == cyc) begin
        check($sformatf("valid_l%0d", lat[k]), 32'(rsp_valid[k]), 32'd1);
        check($sformatf("err_l%0d", lat[k]), 32'(rsp_err[k]), 32'(acc_q[head[k]].err));
        check($sformatf("rdata_l%0d", lat[k]), rsp_rdata[k], acc_q[head[k]].data);
        head[k]++;
      end else begin
        check($sformatf("idle_valid_l%0d", lat[k]), 32'(rsp_valid[k]), 32'd0);
        check($sformatf("idle_err_l%0d", lat[k]), 32'(rsp_err[k]), 32'd0);
        check($sformatf("idle_rdata_l%0d", lat[k]), rsp_rdata[k], 32'h0);
      end
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [AW-1:0] a, input logic [31:0] wd);
    acc_t e;
    req_valid  = v;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    cyc++;
    if (v && ready_m) begin
      model(we, f3, a, wd, e.err, e.data);
      e.cyc = cyc;
      acc_q.push_back(e);
      $display("TXN cyc=%0d we=%0b f3=%0d addr=%h wdata=%h exp_err=%0b exp_rdata=%h",
               cyc, we, f3, a, wd, e.err, e.data);
    end
    if (rst_n) ready_m = 1'b1;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'b000, '0, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = 32'h0;

    // Reset held with clock running, then release: ready rises on the next edge.
    repeat (3) begin
      @(posedge clk);
      #1;
      check_outputs();
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs();
    idle(1);

    // Fill the low 64 words so later random loads read known data.
    for (int w = 0; w < 64; w++) drive(1'b1, 1'b1, 3'b010, AW'(w * 4), $urandom);

    // Sized loads of a known word.
    drive(1'b1, 1'b1, 3'b010, 12'h010, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 3'b010, 12'h010, 32'h0);
    drive(1'b1, 1'b0, 3'b000, 12'h013, 32'h0);
    drive(1'b1, 1'b0, 3'b100, 12'h013, 32'h0);
    drive(1'b1, 1'b0, 3'b001, 12'h012, 32'h0);
    drive(1'b1, 1'b0, 3'b101, 12'h012, 32'h0);

    // Partial stores merge into the word.
    drive(1'b1, 1'b1, 3'b000, 12'h011, 32'hFFFFFF55);
    drive(1'b1, 1'b0, 3'b010, 12'h010, 32'h0);
    drive(1'b1, 1'b1, 3'b001, 12'h012, 32'hABCD1234);
    drive(1'b1, 1'b0, 3'b010, 12'h010, 32'h0);

    // Error cases, then confirm the word is untouched.
    drive(1'b1, 1'b0, 3'b010, 12'h002, 32'h0);
    drive(1'b1, 1'b1, 3'b001, 12'h001, 32'h0BAD0BAD);
    drive(1'b1, 1'b0, 3'b011, 12'h010, 32'h0);
    drive(1'b1, 1'b0, 3'b010, AW'(WORDS * 4), 32'h0);
    drive(1'b1, 1'b1, 3'b100, 12'h010, 32'h11111111);
    drive(1'b1, 1'b0, 3'b010, 12'h010, 32'h0);

    // Store immediately followed by a load of the same word.
    drive(1'b1, 1'b1, 3'b010, 12'h020, 32'hC0FFEE42);
    drive(1'b1, 1'b0, 3'b010, 12'h020, 32'h0);
    idle(3);

    // Randomized traffic: mostly the filled region, occasionally out of range.
    for (int i = 0; i < 300; i++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 15) == 0) a = AW'($urandom_range(WORDS * 4, 4095));
      else                            a = AW'($urandom_range(0, 255));
      drive($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), a, $urandom);
    end
    idle(3);

    // Reset with loads in flight: those responses vanish, stored data survives.
    drive(1'b1, 1'b1, 3'b010, 12'h020, 32'h5A5AA5A5);
    drive(1'b1, 1'b0, 3'b010, 12'h020, 32'h0);
    drive(1'b1, 1'b0, 3'b000, 12'h021, 32'h0);
    #1;
    rst_n   = 1'b0;
    ready_m = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) head[k] = acc_q.size();
    check_outputs();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_outputs();
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    drive(1'b1, 1'b0, 3'b010, 12'h020, 32'h0);
    drive(1'b1, 1'b0, 3'b010, 12'h010, 32'h0);
    idle(4);

    for (int k = 0; k < 3; k++)
      check($sformatf("drain_l%0d", lat[k]), 32'(head[k]), 32'(acc_q.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
